// File: rtl/buzzer_arbiter.sv
// Fixed-priority owner of the board buzzer: grants one of three tone requesters,
// generates its pulse train, and changes owner only at period ends followed by a silent gap.
module buzzer_arbiter #(
    parameter int GAP_CYC    = 50000,
    parameter int DUTY_SHIFT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [19:0] cycle0,
    input  logic [19:0] cycle1,
    input  logic [19:0] cycle2,
    output logic [2:0]  grant,
    output logic        busy,
    output logic        buzzer
);

    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        state_q,   state_d;
    logic [2:0]    grant_q,   grant_d;
    logic [19:0]   cyc_lat_q, cyc_lat_d;
    logic [19:0]   hz_cnt_q,  hz_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          buzzer_q,  buzzer_d;

    logic [2:0]    win_s;
    logic [19:0]   win_cyc_s;
    logic [19:0]   owner_cyc_s;
    logic [19:0]   last_s;
    logic [19:0]   low_thr_s;
    logic          period_end_s;
    logic          owner_keep_s;
    logic          higher_req_s;

    // Fixed-priority winner (lowest index) and its period input.
    always_comb begin
        win_s     = 3'b000;
        win_cyc_s = 20'd0;
        if (req[0]) begin
            win_s     = 3'b001;
            win_cyc_s = cycle0;
        end else if (req[1]) begin
            win_s     = 3'b010;
            win_cyc_s = cycle1;
        end else if (req[2]) begin
            win_s     = 3'b100;
            win_cyc_s = cycle2;
        end else begin
            win_s     = 3'b000;
            win_cyc_s = 20'd0;
        end
    end

    // Current owner's period input, sampled only at period boundaries.
    always_comb begin
        owner_cyc_s = 20'd0;
        case (grant_q)
            3'b001:  owner_cyc_s = cycle0;
            3'b010:  owner_cyc_s = cycle1;
            3'b100:  owner_cyc_s = cycle2;
            default: owner_cyc_s = 20'd0;
        endcase
    end

    // A latched period of 0 behaves as period 1, so every cycle is a boundary.
    assign last_s       = (cyc_lat_q == 20'd0) ? 20'd0 : (cyc_lat_q - 20'd1);
    assign period_end_s = (hz_cnt_q == last_s);
    assign low_thr_s    = cyc_lat_q >> DUTY_SHIFT;
    assign owner_keep_s = |(req & grant_q);
    // For a one-hot owner, owner-1 is the mask of all higher-priority bits.
    assign higher_req_s = |(req & (grant_q - 3'd1));

    // Next-state, grant, counter and buzzer computation.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cyc_lat_d = cyc_lat_q;
        hz_cnt_d  = hz_cnt_q;
        gap_cnt_d = gap_cnt_q;
        buzzer_d  = !((state_q == ST_TONE) && (hz_cnt_q < low_thr_s));
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d   = ST_TONE;
                    grant_d   = win_s;
                    cyc_lat_d = win_cyc_s;
                    hz_cnt_d  = 20'd0;
                end else begin
                    grant_d  = 3'b000;
                    hz_cnt_d = 20'd0;
                end
            end
            ST_TONE: begin
                if (period_end_s) begin
                    hz_cnt_d = 20'd0;
                    if (!owner_keep_s || higher_req_s) begin
                        state_d   = ST_GAP;
                        grant_d   = 3'b000;
                        gap_cnt_d = GW'(GAP_CYC - 1);
                    end else begin
                        cyc_lat_d = owner_cyc_s;
                    end
                end else begin
                    hz_cnt_d = hz_cnt_q + 20'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (|req) begin
                        state_d   = ST_TONE;
                        grant_d   = win_s;
                        cyc_lat_d = win_cyc_s;
                        hz_cnt_d  = 20'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                grant_d   = 3'b000;
                hz_cnt_d  = 20'd0;
                gap_cnt_d = '0;
                buzzer_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 3'b000;
            cyc_lat_q <= 20'd0;
            hz_cnt_q  <= 20'd0;
            gap_cnt_q <= '0;
            buzzer_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cyc_lat_q <= cyc_lat_d;
            hz_cnt_q  <= hz_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            buzzer_q  <= buzzer_d;
        end
    end

    assign grant  = grant_q;
    assign busy   = (state_q != ST_IDLE);
    assign buzzer = buzzer_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter: per-cycle expected outputs are queued with the
// stimulus and popped/compared after each clock edge.
module tb_buzzer_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [19:0] cycle0;
    logic [19:0] cycle1;
    logic [19:0] cycle2;
    logic [2:0]  grant;
    logic        busy;
    logic        buzzer;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] g;
        logic       b;
        logic       z;
        string      tag;
    } exp_t;

    exp_t sb[$];

    buzzer_arbiter #(
        .GAP_CYC    (4),
        .DUTY_SHIFT (5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .cycle0 (cycle0),
        .cycle1 (cycle1),
        .cycle2 (cycle2),
        .grant  (grant),
        .busy   (busy),
        .buzzer (buzzer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int n, input logic [2:0] g, input logic b, input logic z,
                        input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.g = g; e.b = b; e.z = z; e.tag = tag;
            sb.push_back(e);
        end
    endtask

    // Entries idx_from..idx_to-1 of a tone period; entry i is the output after the edge
    // that leaves hz_cnt at i, so the buzzer shows the comparison for hz_cnt = i-1.
    task automatic push_tone(input logic [2:0] g, input int period, input int idx_from,
                             input int idx_to, input string tag);
        int low;
        low = period >> 5;
        for (int i = idx_from; i < idx_to; i++)
            push(1, g, 1'b1, !((i >= 1) && (i <= low)), tag);
    endtask

    task automatic push_gap_idle(input string tag);
        push(4, 3'b000, 1'b1, 1'b1, {tag, "_gap"});
        push(1, 3'b000, 1'b0, 1'b1, {tag, "_idle"});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk({e.tag, "_grant"},  20'(grant),  20'(e.g));
            chk({e.tag, "_busy"},   20'(busy),   20'(e.b));
            chk({e.tag, "_buzzer"}, 20'(buzzer), 20'(e.z));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 3'b000;
        cycle0 = 20'd0;
        cycle1 = 20'd0;
        cycle2 = 20'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_grant",  20'(grant),  20'd0);
        chk("reset_busy",   20'(busy),   20'd0);
        chk("reset_buzzer", 20'(buzzer), 20'd1);

        // Single requester, three full periods, drop mid fourth period.
        req = 3'b100; cycle2 = 20'd64;
        for (int p = 0; p < 3; p++) push_tone(3'b100, 64, 0, 64, "single");
        push_tone(3'b100, 64, 0, 10, "single");
        drain();
        req = 3'b000;
        push_tone(3'b100, 64, 10, 64, "single_tail");
        push_gap_idle("single");
        drain();

        // Preemption by the alarm at hz_cnt = 10 of a 100-cycle music period.
        req = 3'b100; cycle2 = 20'd100;
        push_tone(3'b100, 100, 0, 11, "pre_music");
        drain();
        req = 3'b101; cycle0 = 20'd64;
        push_tone(3'b100, 100, 11, 100, "pre_music_tail");
        push(4, 3'b000, 1'b1, 1'b1, "pre_gap");
        push_tone(3'b001, 64, 0, 64, "pre_alarm");
        drain();
        req = 3'b000;
        push_gap_idle("pre");
        drain();

        // Priority tie, hand-over to key click, then note change 64 -> 128.
        req = 3'b111; cycle0 = 20'd64; cycle1 = 20'd64; cycle2 = 20'd64;
        push_tone(3'b001, 64, 0, 10, "tie_alarm");
        drain();
        req = 3'b110;
        push_tone(3'b001, 64, 10, 64, "tie_alarm_tail");
        push(4, 3'b000, 1'b1, 1'b1, "tie_gap");
        push_tone(3'b010, 64, 0, 6, "tie_click");
        drain();
        cycle1 = 20'd128;
        push_tone(3'b010, 64, 6, 64, "note_old");
        push_tone(3'b010, 128, 0, 128, "note_new");
        drain();
        req = 3'b000;
        push_gap_idle("note");
        drain();

        // Rest (period 20 < 32) and zero period.
        req = 3'b100; cycle2 = 20'd20;
        push(40, 3'b100, 1'b1, 1'b1, "rest20");
        drain();
        cycle2 = 20'd0;
        push(5, 3'b100, 1'b1, 1'b1, "rest0");
        drain();
        req = 3'b000;
        push_gap_idle("rest0");
        drain();

        // Reset during a buzzer-low cycle.
        req = 3'b100; cycle2 = 20'd64;
        push_tone(3'b100, 64, 0, 2, "rst_pre");
        drain();
        chk("rst_pre_low", 20'(buzzer), 20'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_buzzer", 20'(buzzer), 20'd1);
        chk("rst_async_grant",  20'(grant),  20'd0);
        chk("rst_async_busy",   20'(busy),   20'd0);
        #1;
        rst_n = 1'b1;
        push_tone(3'b100, 64, 0, 4, "rst_regrant");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buzzer_arbiter.md
# buzzer_arbiter

Shares the single board buzzer between three tone requesters: an alarm source, a key-click source and the music player. It grants one requester at a time by fixed priority and generates the buzzer waveform from the granted requester's period value. Preemption and hand-over occur only at tone-period boundaries, followed by a silent gap, so the buzzer never produces truncated pulses. It sits between the requester blocks and the `buzzer` pin, and replaces each requester's direct drive of the pin.

## Interface
- `GAP_CYC`, 50000: silent cycles inserted after every grant release (1 ms at 50 MHz); must be ≥1.
- `DUTY_SHIFT`, 5: low-time threshold is `cycle >> DUTY_SHIFT` (volume control; 1/32 duty by default).
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 3: level requests; bit 0 is the alarm (highest priority), bit 1 the key click, bit 2 the music player (lowest).
- `cycle0` in 20: tone period in clk cycles for requester 0.
- `cycle1` in 20: tone period for requester 1.
- `cycle2` in 20: tone period for requester 2.
- `grant` out 3: one-hot current owner; all zero when idle or in the gap.
- `busy` out 1: high in TONE and GAP.
- `buzzer` out 1: active-low buzzer drive.

## Operation
- States:
  - IDLE: buzzer high, grant 0, counters 0.
  - TONE: one requester owns the buzzer.
  - GAP: silence.
- Arbitration (IDLE, and at the end of GAP):
  - The lowest-index asserted `req` bit wins.
  - Enter TONE with `grant` set to the winner's one-hot, `cyc_lat` set to the winner's cycle input, and `hz_cnt` = 0.
- TONE:
  - `hz_cnt` counts 0 … `cyc_lat`−1, then wraps. `cyc_lat` = 0 is treated as period 1.
  - Buzzer is low iff `hz_cnt` < (`cyc_lat` >> `DUTY_SHIFT`). A period below 2^`DUTY_SHIFT` therefore yields a rest (buzzer stays high while the grant is held).
- Period boundary (`hz_cnt` == `cyc_lat`−1 in TONE):
  - If the owner's `req` is low, or any higher-priority `req` is high: go to GAP, clear `grant`, load the gap counter to `GAP_CYC`−1.
  - Otherwise: stay in TONE and reload `cyc_lat` from the owner's current cycle input. Note changes take effect only here.
- The owner dropping `req` mid-period finishes the current period; there is no truncation.
- A lower-priority request during TONE is ignored until the owner releases.
- GAP: the counter decrements to 0, then arbitration runs in the same cycle.
  - If any `req` is high: go to TONE.
  - Otherwise: go to IDLE.
- Cycle inputs of non-owners are don't-care. The owner's cycle input is sampled only at grant and at period boundaries.
- `busy` = (state != IDLE).

## Timing
- Reset values: `buzzer` = 1, `grant` = 0, `busy` = 0, state IDLE, all counters 0, `cyc_lat` 0.
- Reset asserted mid-tone: all outputs return to reset values asynchronously. No pending request is remembered.
- `req` sampled high at edge k in IDLE:
  - `grant` and `busy` valid after edge k.
  - `hz_cnt` = 0 after edge k.
  - `buzzer` is registered from the TONE comparison, so the first low appears after edge k+1.
- `buzzer` lags state/`hz_cnt` by one cycle throughout. On entry to GAP or IDLE, `buzzer` goes high one cycle after `grant` clears.
- GAP lasts exactly `GAP_CYC` cycles with `grant` = 0. A new `grant` appears on the cycle after the counter reaches 0.
- Simultaneous requests: the lowest index wins. Requests that appear in the same cycle as GAP expiry are included in that arbitration.
- Widths: `hz_cnt` and `cyc_lat` are 20-bit. The gap counter is sized by `$clog2(GAP_CYC+1)`.

## Test plan
- Test parameters: `GAP_CYC`=4, `DUTY_SHIFT`=5.
- Single requester: `req`=3'b100, `cycle2`=64 held for 3 periods.
  - Required: `grant`=3'b100.
  - `buzzer` low for exactly 2 cycles in each 64-cycle period, first low one cycle after `grant`.
  - After `req` drops, the period finishes, then 4 gap cycles, then IDLE.
- Preemption: music owning with `cycle2`=100; assert `req[0]` with `cycle0`=64 at `hz_cnt`=10.
  - Required: the music period completes (cycles 11–99).
  - `grant` goes to 0 for 4 cycles, then becomes 3'b001.
  - Buzzer low 2 cycles per 64.
- Priority tie: `req`=3'b111 from IDLE.
  - Required: `grant`=3'b001.
  - Drop `req[0]`: after the period end and the gap, `grant`=3'b010.
- Note change: owner `cycle1` changes 64→128 at `hz_cnt`=5.
  - Required: the current period stays 64 cycles; the next period is 128 cycles with 4 low cycles.
- Rest and zero: `cycle2`=20, then `cycle2`=0.
  - Required: `grant` held and `buzzer` constantly high.
  - With `cycle2`=0, a period boundary occurs every cycle, so a drop of `req` is seen immediately.
- Reset mid-tone: `rst_n` low during a buzzer-low cycle.
  - Required: `buzzer`=1, `grant`=0, `busy`=0 immediately.
  - After release with `req` held, a fresh grant occurs one edge later.
